// File: rtl/if_stage_reg.sv
// Instruction-fetch stage: program counter, fetch address, IF/ID pipeline
// register and a saturating stall-cycle counter.
module if_stage_reg #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_instr_i,
  output logic [31:0]       ifid_instr_o,
  output logic [ADDR_W-1:0] ifid_pc4_o,
  output logic              ifid_valid_o,
  output logic [15:0]       stall_cnt_o
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] pc_next;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  // Sequential PC increment; wraps naturally at the top of the address space.
  always_comb begin
    pc_plus4 = pc + PC_STEP;
  end

  // Next PC: redirect wins over stall, stall holds, otherwise advance.
  // Redirect targets are forced word-aligned.
  always_comb begin
    pc_next = pc_plus4;
    if (redirect_i) begin
      pc_next = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    end else if (stall_i) begin
      pc_next = pc;
    end
  end

  // Program counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  assign imem_addr_o = pc;

  // IF/ID register: flush inserts a bubble even while stalled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ifid_instr_o <= '0;
      ifid_pc4_o   <= '0;
      ifid_valid_o <= 1'b0;
    end else if (flush_i) begin
      ifid_instr_o <= '0;
      ifid_pc4_o   <= '0;
      ifid_valid_o <= 1'b0;
    end else if (!stall_i) begin
      ifid_instr_o <= imem_instr_i;
      ifid_pc4_o   <= pc_plus4;
      ifid_valid_o <= 1'b1;
    end
  end

  // Stall-cycle counter: counts only stalls that are not overridden by a
  // flush, and sticks at all-ones until the next reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_i && !flush_i && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end

endmodule
